matrix_pwm_driver: RTL

- Parametrised successor to the fixed 8x8 bicolour dot-matrix driver.
- Scans a ROWS x COLS red/green matrix row by row.
- Each channel gets per-pixel PWM brightness of 2^PWM_BITS levels.
- Pixels come from a double-buffered frame store written through a pixel port; buffers swap only at frame boundaries, so the display never tears.

---
 rtl/matrix_pwm_driver_if.sv | 32 +++
 rtl/matrix_pwm_driver.sv | 121 ++++++++++++
 2 files changed

// File: rtl/matrix_pwm_driver_if.sv
// Pixel-write, swap and matrix-drive signals of the PWM dot-matrix driver.
// The master side writes pixels and requests swaps; the slave side is the driver.
interface matrix_pwm_driver_if #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int PWM_BITS = 2
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic                wr_en;
    logic [ROW_W-1:0]    wr_row;
    logic [COL_W-1:0]    wr_col;
    logic [PWM_BITS-1:0] wr_r;
    logic [PWM_BITS-1:0] wr_g;
    logic                swap_req;
    logic                swap_done;
    logic                frame_start;
    logic [ROWS-1:0]     rowO;
    logic [COLS-1:0]     colR;
    logic [COLS-1:0]     colG;

    modport master (
        output wr_en, wr_row, wr_col, wr_r, wr_g, swap_req,
        input  swap_done, frame_start, rowO, colR, colG
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_r, wr_g, swap_req,
        output swap_done, frame_start, rowO, colR, colG
    );
endinterface

// File: rtl/matrix_pwm_driver.sv
// Row-scanned red/green dot-matrix driver with per-pixel PWM and a
// double-buffered frame store that only swaps on frame boundaries.
module matrix_pwm_driver #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int PWM_BITS = 2,
    parameter int ROW_DIV  = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    matrix_pwm_driver_if.slave      bus
);
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DIV_W  = $clog2(ROW_DIV);
    localparam int S      = (1 << PWM_BITS) - 1;
    localparam int DEPTH  = ROWS * COLS;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(ROW_DIV - 1);
    localparam logic [PWM_BITS-1:0] SLOT_LAST = PWM_BITS'(S - 1);
    localparam logic [ROW_W-1:0]    ROW_LAST  = ROW_W'(ROWS - 1);

    typedef logic [2*PWM_BITS-1:0] pix_t;

    // Each entry holds {red, green}; front=0 displays mem_a, front=1 displays mem_b.
    pix_t mem_a [DEPTH];
    pix_t mem_b [DEPTH];

    logic [DIV_W-1:0]    div;
    logic [PWM_BITS-1:0] slot;
    logic [ROW_W-1:0]    row;
    logic                front;
    logic                pending;
    logic                swap_hit;

    logic                div_wrap;
    logic                slot_wrap;
    logic                frame_end;
    logic                blank;
    logic                wr_ok;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_base;
    logic [COLS-1:0]     col_r_nx;
    logic [COLS-1:0]     col_g_nx;
    pix_t                pix;

    assign div_wrap  = (div == DIV_LAST);
    assign slot_wrap = div_wrap && (slot == SLOT_LAST);
    assign frame_end = slot_wrap && (row == ROW_LAST);
    assign blank     = (div == '0) && (slot == '0);

    assign wr_ok   = bus.wr_en && (int'(bus.wr_row) < ROWS) && (int'(bus.wr_col) < COLS);
    assign wr_addr = ADDR_W'(int'(bus.wr_row) * COLS + int'(bus.wr_col));
    assign rd_base = ADDR_W'(int'(row) * COLS);

    // Writes use the pre-toggle front, so a write on the swap edge lands in the new front.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (front) begin
                mem_a[wr_addr] <= {bus.wr_r, bus.wr_g};
            end else begin
                mem_b[wr_addr] <= {bus.wr_r, bus.wr_g};
            end
        end
    end

    always_comb begin
        col_r_nx = '0;
        col_g_nx = '0;
        pix      = '0;
        for (int c = 0; c < COLS; c++) begin
            pix = front ? mem_b[rd_base + ADDR_W'(c)] : mem_a[rd_base + ADDR_W'(c)];
            col_r_nx[c] = (pix[2*PWM_BITS-1:PWM_BITS] > slot);
            col_g_nx[c] = (pix[PWM_BITS-1:0] > slot);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div             <= '0;
            slot            <= '0;
            row             <= '0;
            front           <= 1'b0;
            pending         <= 1'b0;
            swap_hit        <= 1'b0;
            bus.rowO        <= '1;
            bus.colR        <= '0;
            bus.colG        <= '0;
            bus.swap_done   <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            if (div_wrap) begin
                div <= '0;
                if (slot == SLOT_LAST) begin
                    slot <= '0;
                    row  <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    slot <= slot + 1'b1;
                end
            end else begin
                div <= div + 1'b1;
            end

            bus.rowO        <= blank ? '1 : ~(ROWS'(1) << row);
            bus.colR        <= blank ? '0 : col_r_nx;
            bus.colG        <= blank ? '0 : col_g_nx;
            bus.frame_start <= blank && (row == '0);

            // swap_hit delays the done pulse by one clock so it lines up with frame_start.
            bus.swap_done <= swap_hit;
            swap_hit      <= 1'b0;
            if (frame_end && (pending || bus.swap_req)) begin
                front    <= ~front;
                pending  <= 1'b0;
                swap_hit <= 1'b1;
            end else if (bus.swap_req) begin
                pending <= 1'b1;
            end
        end
    end
endmodule
